// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick merge, rotation and coin stretch for arcade cores; optional AUTOFIRE_EN
module arcade_input_mapper #(
    parameter int          NUM_PLAYERS = 2,
    parameter int          BTN_W       = 2,
    parameter logic [15:0] COIN_CYCLES = 16'd2400,
    parameter logic [15:0] AF_HALF     = 16'd3000
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [10:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joy_i,
    input  logic [1:0]                rot_i,
`ifdef AUTOFIRE_EN
    input  logic [NUM_PLAYERS-1:0]    autofire_i,
`endif
    output logic [4*NUM_PLAYERS-1:0]  dir_o,
    output logic [BTN_W*NUM_PLAYERS-1:0] btn_o,
    output logic [NUM_PLAYERS-1:0]    start_o,
    output logic [NUM_PLAYERS-1:0]    coin_o,
    output logic                      key_any_o
);

    typedef enum logic {
        C_IDLE,
        C_PULSE
    } coin_st_t;

    // Player 1 key regs: 0 U, 1 D, 2 L, 3 R, 4 btn0 (029), 5 btn0 (014), 6 btn1, 7 start, 8 coin
    logic [8:0] r_k1;
    // Player 2 key regs: 0 U, 1 D, 2 L, 3 R, 4 btn0, 5 btn1, 6 start, 7 coin
    logic [7:0] r_k2;
    logic       r_tog;
    logic       r_key_any;
    logic       w_evt;
    logic       w_unused_joy;

    assign w_evt        = ps2_key[10] ^ r_tog;
    assign key_any_o    = r_key_any;
    // Unused joystick fields (bits 14/15, buttons beyond BTN_W) are deliberately ignored
    assign w_unused_joy = ^joy_i;

    // Direction vector is {U,D,L,R}; each case names which input feeds each output
    function automatic logic [3:0] f_rotate(input logic [3:0] d, input logic [1:0] r);
        case (r)
            2'd0:    f_rotate = d;
            2'd1:    f_rotate = {d[1], d[0], d[2], d[3]};
            2'd2:    f_rotate = {d[2], d[3], d[0], d[1]};
            default: f_rotate = {d[0], d[1], d[3], d[2]};
        endcase
    endfunction

    // Track the PS/2 toggle bit and latch the pressed state of mapped keys on each event
    always_ff @(posedge clk_sys) begin
        r_tog <= ps2_key[10];
        if (reset) begin
            r_k1 <= '0;
            r_k2 <= '0;
        end else if (w_evt) begin
            case ({ps2_key[8], ps2_key[7:0]})
                9'h175:  r_k1[0] <= ps2_key[9];
                9'h172:  r_k1[1] <= ps2_key[9];
                9'h16B:  r_k1[2] <= ps2_key[9];
                9'h174:  r_k1[3] <= ps2_key[9];
                9'h029:  r_k1[4] <= ps2_key[9];
                9'h014:  r_k1[5] <= ps2_key[9];
                9'h011:  r_k1[6] <= ps2_key[9];
                9'h016:  r_k1[7] <= ps2_key[9];
                9'h02E:  r_k1[8] <= ps2_key[9];
                9'h02D:  r_k2[0] <= ps2_key[9];
                9'h02B:  r_k2[1] <= ps2_key[9];
                9'h023:  r_k2[2] <= ps2_key[9];
                9'h034:  r_k2[3] <= ps2_key[9];
                9'h01C:  r_k2[4] <= ps2_key[9];
                9'h01B:  r_k2[5] <= ps2_key[9];
                9'h01E:  r_k2[6] <= ps2_key[9];
                9'h036:  r_k2[7] <= ps2_key[9];
                default: ;
            endcase
        end
    end

    // Registered "any mapped key held" flag
    always_ff @(posedge clk_sys) begin
        if (reset) r_key_any <= 1'b0;
        else       r_key_any <= (|r_k1) | (|r_k2);
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0]       w_kd;
        logic [BTN_W-1:0] w_kb;
        logic             w_ks;
        logic             w_kc;
        logic [3:0]       w_rd;
        logic [BTN_W-1:0] w_rb;
        logic             w_rs;
        logic             w_rc;
        logic             w_req;
        logic [3:0]       r_dir;
        logic [BTN_W-1:0] r_btn;
        logic             r_start;
        coin_st_t         r_st;
        logic [15:0]      r_cnt;
        logic             r_coin;
        logic             r_req;
        logic             r_req_d;
`ifdef AUTOFIRE_EN
        logic             r_af_on;
        logic [15:0]      r_af_cnt;
`endif

        // Keyboard only reaches players 1 and 2
        if (p == 0) begin : g_kb1
            assign w_kd = {r_k1[0], r_k1[1], r_k1[2], r_k1[3]};
            assign w_kb = BTN_W'({r_k1[6], r_k1[4] | r_k1[5]});
            assign w_ks = r_k1[7];
            assign w_kc = r_k1[8];
        end else if (p == 1) begin : g_kb2
            assign w_kd = {r_k2[0], r_k2[1], r_k2[2], r_k2[3]};
            assign w_kb = BTN_W'({r_k2[5], r_k2[4]});
            assign w_ks = r_k2[6];
            assign w_kc = r_k2[7];
        end else begin : g_kbn
            assign w_kd = '0;
            assign w_kb = '0;
            assign w_ks = 1'b0;
            assign w_kc = 1'b0;
        end

        assign w_rd = joy_i[16*p +: 4] | w_kd;
        assign w_rb = joy_i[16*p+4 +: BTN_W] | w_kb;
        assign w_rs = joy_i[16*p+12] | w_ks;
        assign w_rc = joy_i[16*p+13] | w_kc;

        // Start + button1 doubles as a coin insert when a second button exists
        if (BTN_W >= 2) begin : g_combo
            assign w_req = w_rc | (w_rs & w_rb[1]);
        end else begin : g_nocombo
            assign w_req = w_rc;
        end

        // Registered direction (rotated), buttons and start; button 0 may be autofired
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_dir   <= '0;
                r_btn   <= '0;
                r_start <= 1'b0;
`ifdef AUTOFIRE_EN
                r_af_on  <= 1'b0;
                r_af_cnt <= '0;
`endif
            end else begin
                r_dir   <= f_rotate(w_rd, rot_i);
                r_btn   <= w_rb;
                r_start <= w_rs;
`ifdef AUTOFIRE_EN
                if (autofire_i[p] && w_rb[0]) begin
                    if (!r_af_on) begin
                        r_af_on  <= 1'b1;
                        r_btn[0] <= 1'b1;
                        r_af_cnt <= AF_HALF - 16'd1;
                    end else if (r_af_cnt == 16'd0) begin
                        r_btn[0] <= ~r_btn[0];
                        r_af_cnt <= AF_HALF - 16'd1;
                    end else begin
                        r_btn[0] <= r_btn[0];
                        r_af_cnt <= r_af_cnt - 16'd1;
                    end
                end else begin
                    r_af_on  <= 1'b0;
                    r_af_cnt <= '0;
                end
`endif
            end
        end

        // Coin stretcher: a request rising edge in IDLE starts a fixed-length pulse
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_st    <= C_IDLE;
                r_cnt   <= '0;
                r_coin  <= 1'b0;
                r_req   <= 1'b0;
                r_req_d <= 1'b0;
            end else begin
                r_req   <= w_req;
                r_req_d <= r_req;
                case (r_st)
                    C_IDLE: begin
                        if (r_req && !r_req_d) begin
                            r_st   <= C_PULSE;
                            r_cnt  <= COIN_CYCLES - 16'd1;
                            r_coin <= 1'b1;
                        end
                    end
                    C_PULSE: begin
                        if (r_cnt == 16'd0) begin
                            r_st   <= C_IDLE;
                            r_coin <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    default: r_st <= C_IDLE;
                endcase
            end
        end

        assign dir_o[4*p +: 4]         = r_dir;
        assign btn_o[BTN_W*p +: BTN_W] = r_btn;
        assign start_o[p]              = r_start;
        assign coin_o[p]               = r_coin;
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - self-checking bench for arcade_input_mapper
module tb_arcade_input_mapper;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic [10:0] ps2_key  = 11'h400;
    logic [31:0] joy      = '0;
    logic [1:0]  rot      = '0;
    logic [1:0]  autofire = '0;
    wire  [7:0]  dir_o;
    wire  [3:0]  btn_o;
    wire  [1:0]  start_o;
    wire  [1:0]  coin_o;
    wire         key_any_o;

    int n_tests;
    int n_fail;

    arcade_input_mapper #(
        .NUM_PLAYERS(2),
        .BTN_W(2),
        .COIN_CYCLES(16'd5),
        .AF_HALF(16'd3)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ps2_key(ps2_key),
        .joy_i(joy),
        .rot_i(rot),
`ifdef AUTOFIRE_EN
        .autofire_i(autofire),
`endif
        .dir_o(dir_o),
        .btn_o(btn_o),
        .start_o(start_o),
        .coin_o(coin_o),
        .key_any_o(key_any_o)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] joy;
        logic [1:0]  rot;
        logic [7:0]  dir;
        logic [3:0]  btn;
        logic [1:0]  start;
    } vec_t;

    // Key function codes: 0 R, 1 L, 2 D, 3 U, 4 btn0, 5 btn1, 6 start, 7 coin
    typedef struct {
        bit         ext;
        logic [7:0] code;
        int         pl;
        int         fn;
    } kmap_t;

    vec_t  vecs[9];
    kmap_t kmap[17];
    bit    kdown[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_key(input bit pr, input bit ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pr, ext, code};
    endtask

    // Directions as quarter-turn angles counter-clockwise from Right
    function automatic int ang_of_bit(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : (i == 2) ? 3 : 1;
    endfunction

    function automatic int bit_of_ang(input int a);
        return (a == 0) ? 0 : (a == 1) ? 3 : (a == 2) ? 1 : 2;
    endfunction

    // Screen rotation by r quarter turns maps an input at angle a to angle a - r
    task automatic model(output logic [7:0] d, output logic [3:0] b,
                         output logic [1:0] s, output logic ka);
        d  = '0;
        b  = '0;
        s  = '0;
        ka = 1'b0;
        for (int p = 0; p < 2; p++) begin
            logic [7:0] f;
            f = {joy[16*p+13], joy[16*p+12], joy[16*p+5], joy[16*p+4], joy[16*p +: 4]};
            for (int k = 0; k < 17; k++)
                if (kdown[k] && kmap[k].pl == p) f[kmap[k].fn] = 1'b1;
            for (int i = 0; i < 4; i++)
                if (f[i]) d[4*p + bit_of_ang((ang_of_bit(i) - int'(rot) + 4) % 4)] = 1'b1;
            b[2*p]   = f[4];
            b[2*p+1] = f[5];
            s[p]     = f[6];
        end
        for (int k = 0; k < 17; k++) if (kdown[k]) ka = 1'b1;
    endtask

    initial begin
        logic [7:0]  e_d;
        logic [3:0]  e_b;
        logic [1:0]  e_s;
        logic        e_ka;
        logic [11:0] pat;
        int          hi;
        int          w;

        n_tests = 0;
        n_fail  = 0;

        kmap[0]  = '{1'b1, 8'h75, 0, 3};
        kmap[1]  = '{1'b1, 8'h72, 0, 2};
        kmap[2]  = '{1'b1, 8'h6B, 0, 1};
        kmap[3]  = '{1'b1, 8'h74, 0, 0};
        kmap[4]  = '{1'b0, 8'h29, 0, 4};
        kmap[5]  = '{1'b0, 8'h14, 0, 4};
        kmap[6]  = '{1'b0, 8'h11, 0, 5};
        kmap[7]  = '{1'b0, 8'h16, 0, 6};
        kmap[8]  = '{1'b0, 8'h2E, 0, 7};
        kmap[9]  = '{1'b0, 8'h2D, 1, 3};
        kmap[10] = '{1'b0, 8'h2B, 1, 2};
        kmap[11] = '{1'b0, 8'h23, 1, 1};
        kmap[12] = '{1'b0, 8'h34, 1, 0};
        kmap[13] = '{1'b0, 8'h1C, 1, 4};
        kmap[14] = '{1'b0, 8'h1B, 1, 5};
        kmap[15] = '{1'b0, 8'h1E, 1, 6};
        kmap[16] = '{1'b0, 8'h36, 1, 7};
        for (int k = 0; k < 17; k++) kdown[k] = 1'b0;

        vecs[0] = '{32'h0000_0008, 2'd0, 8'h08, 4'h0, 2'b00};
        vecs[1] = '{32'h0000_0008, 2'd1, 8'h01, 4'h0, 2'b00};
        vecs[2] = '{32'h0000_0008, 2'd2, 8'h04, 4'h0, 2'b00};
        vecs[3] = '{32'h0000_0008, 2'd3, 8'h02, 4'h0, 2'b00};
        vecs[4] = '{32'h0001_0000, 2'd0, 8'h10, 4'h0, 2'b00};
        vecs[5] = '{32'h0001_0000, 2'd1, 8'h40, 4'h0, 2'b00};
        vecs[6] = '{32'h1000_0030, 2'd0, 8'h00, 4'h3, 2'b10};
        vecs[7] = '{32'h0000_C0C0, 2'd0, 8'h00, 4'h0, 2'b00};
        vecs[8] = '{32'h0006_1000, 2'd2, 8'h90, 4'h0, 2'b01};

        // Reset with the toggle bit high: nothing may register as a key event
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_dir", dir_o, 0);
        check("rst_btn", btn_o, 0);
        check("rst_start", start_o, 0);
        check("rst_coin", coin_o, 0);
        check("rst_key_any", key_any_o, 0);

        // Joystick vectors, one edge of latency each
        for (int i = 0; i < 9; i++) begin
            joy = vecs[i].joy;
            rot = vecs[i].rot;
            @(negedge clk_sys);
            check($sformatf("vec%0d_dir", i), dir_o, vecs[i].dir);
            check($sformatf("vec%0d_btn", i), btn_o, vecs[i].btn);
            check($sformatf("vec%0d_start", i), start_o, vecs[i].start);
        end
        joy = '0;
        rot = '0;
        repeat (2) @(negedge clk_sys);

        // PS/2 press and release of extended Up: two edges of latency
        send_key(1'b1, 1'b1, 8'h75);
        @(negedge clk_sys);
        check("kb_press_1edge", dir_o, 8'h00);
        @(negedge clk_sys);
        check("kb_press_2edge", dir_o, 8'h08);
        check("kb_key_any_on", key_any_o, 1);
        send_key(1'b0, 1'b1, 8'h75);
        @(negedge clk_sys);
        check("kb_rel_1edge", dir_o, 8'h08);
        @(negedge clk_sys);
        check("kb_rel_2edge", dir_o, 8'h00);
        check("kb_key_any_off", key_any_o, 0);

        // Randomised joystick/rotation/keyboard traffic against the reference model
        for (int it = 0; it < 150; it++) begin
            joy = $urandom & 32'h3FFF_3FFF;
            rot = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                int k;
                bit pr;
                k  = $urandom_range(0, 19);
                pr = 1'($urandom_range(0, 1));
                if (k < 17) begin
                    send_key(pr, kmap[k].ext, kmap[k].code);
                    kdown[k] = pr;
                end else if (k == 17) begin
                    send_key(pr, 1'b0, 8'h75);
                end else if (k == 18) begin
                    send_key(pr, 1'b1, 8'h29);
                end else begin
                    send_key(pr, 1'b1, 8'h1C);
                end
            end
            repeat (2) @(negedge clk_sys);
            model(e_d, e_b, e_s, e_ka);
            check($sformatf("rnd%0d_dir", it), dir_o, e_d);
            check($sformatf("rnd%0d_btn", it), btn_o, e_b);
            check($sformatf("rnd%0d_start", it), start_o, e_s);
            check($sformatf("rnd%0d_key_any", it), key_any_o, e_ka);
        end

        joy   = '0;
        rot   = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        for (int k = 0; k < 17; k++) kdown[k] = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst2_key_any", key_any_o, 0);

        // Coin key held for one cycle
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) send_key(1'b1, 1'b0, 8'h2E);
            if (i == 1) send_key(1'b0, 1'b0, 8'h2E);
            @(negedge clk_sys);
            if (coin_o[0]) hi++;
        end
        check("coin_short_len", hi, 5);

        // Coin key held for 20 cycles: no retrigger while held
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0)  send_key(1'b1, 1'b0, 8'h2E);
            if (i == 20) send_key(1'b0, 1'b0, 8'h2E);
            @(negedge clk_sys);
            if (coin_o[0]) hi++;
        end
        check("coin_long_len", hi, 5);

        // Second press inside the pulse must not extend it
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) send_key(1'b1, 1'b0, 8'h2E);
            if (i == 1) send_key(1'b0, 1'b0, 8'h2E);
            if (i == 3) send_key(1'b1, 1'b0, 8'h2E);
            if (i == 4) send_key(1'b0, 1'b0, 8'h2E);
            @(negedge clk_sys);
            if (coin_o[0]) hi++;
        end
        check("coin_retrig_len", hi, 5);
        check("coin_p1_idle", coin_o[1], 0);

        // Player 2 start + button1 combo coin, then reset mid-pulse
        joy = 32'h1020_0000;
        @(negedge clk_sys);
        check("combo_start", start_o, 2'b10);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (coin_o[1]) hi++;
        end
        check("combo_coin_len", hi, 5);
        joy = '0;
        repeat (3) @(negedge clk_sys);
        joy = 32'h1020_0000;
        w = 0;
        while (w < 10 && !coin_o[1]) begin
            @(negedge clk_sys);
            w++;
        end
        check("combo_coin_rise", coin_o[1], 1);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check("reset_mid_coin", coin_o[1], 0);
        check("reset_mid_start", start_o, 0);
        joy   = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);

`ifdef AUTOFIRE_EN
        // Autofire on player 1 button 0, half-period 3
        autofire = 2'b01;
        send_key(1'b1, 1'b0, 8'h29);
        @(negedge clk_sys);
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            pat = {pat[10:0], btn_o[0]};
        end
        check("af_pattern", pat, 12'b111000111000);
        send_key(1'b0, 1'b0, 8'h29);
        repeat (2) @(negedge clk_sys);
        check("af_release", btn_o[0], 0);
        autofire = '0;
`else
        pat = '0;
        send_key(1'b1, 1'b0, 8'h29);
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 12; i++) begin
            pat = {pat[10:0], btn_o[0]};
            @(negedge clk_sys);
        end
        check("btn0_steady", pat, 12'hFFF);
        send_key(1'b0, 1'b0, 8'h29);
        repeat (2) @(negedge clk_sys);
        check("btn0_release", btn_o[0], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
